multi_port_reg_file: RTL and testbench

MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

---
 rtl/multi_port_reg_file.sv | 156 +++++++++++++++
 tb/tb_multi_port_reg_file.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_reg_file.sv
// ---------------------------------------------------------------------------
// multi_port_reg_file
//
// Purpose:
//   Register file with two write ports, NUM_RD combinational read ports and a
//   pending-bit scoreboard. The scoreboard tracks registers whose producer has
//   been issued but whose result has not yet been written back. Register 0 is
//   hardwired to zero and is never pending.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  address width, depth is 2**ADDR_W
//   NUM_RD  number of read ports (1..4)
//   BYPASS  1 = same-cycle write data is forwarded to matching reads
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     asynchronous active-low reset
//   WrEn0/WrAddr0/WrData0     write port 0
//   WrEn1/WrAddr1/WrData1     write port 1 (wins over port 0 on same address)
//   RdAddr                    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RdData                    packed read data, port k at [k*DATA_W +: DATA_W]
//   IssueEn/IssueAddr         mark a destination register as pending
//   Busy                      per-read-port hazard flag
//   PendCount                 registered number of pending registers
// ---------------------------------------------------------------------------
module multi_port_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WrEn0,
  input  logic [ADDR_W-1:0]          WrAddr0,
  input  logic [DATA_W-1:0]          WrData0,
  input  logic                       WrEn1,
  input  logic [ADDR_W-1:0]          WrAddr1,
  input  logic [DATA_W-1:0]          WrData1,
  input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
  output logic [NUM_RD*DATA_W-1:0]   RdData,
  input  logic                       IssueEn,
  input  logic [ADDR_W-1:0]          IssueAddr,
  output logic [NUM_RD-1:0]          Busy,
  output logic [ADDR_W:0]            PendCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [ADDR_W:0]   r_pendCount;

  logic              w_wr0Valid;
  logic              w_wr1Valid;
  logic              w_wr0Shadowed;
  logic              w_issueValid;
  logic [DEPTH-1:0]  w_pendNext;
  logic [ADDR_W:0]   w_pendNextCount;

  // Address 0 is the zero register: any access aimed at it is dropped here so
  // the rest of the logic never has to special-case it on the write side.
  assign w_wr0Valid    = WrEn0 && (WrAddr0 != '0);
  assign w_wr1Valid    = WrEn1 && (WrAddr1 != '0);
  assign w_issueValid  = IssueEn && (IssueAddr != '0);
  assign w_wr0Shadowed = w_wr1Valid && (WrAddr1 == WrAddr0);

  // Storage array. Port 1 has priority, so port 0 is suppressed when both
  // target the same register rather than relying on assignment order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr0Valid && !w_wr0Shadowed) begin
        r_regs[WrAddr0] <= WrData0;
      end
      if (w_wr1Valid) begin
        r_regs[WrAddr1] <= WrData1;
      end
    end
  end

  // Next scoreboard state: write-backs clear first, then an issue sets, so a
  // same-cycle issue to a register being written leaves it pending for the
  // newer producer.
  always_comb begin
    w_pendNext = r_pending;
    if (w_wr0Valid) begin
      w_pendNext[WrAddr0] = 1'b0;
    end
    if (w_wr1Valid) begin
      w_pendNext[WrAddr1] = 1'b0;
    end
    if (w_issueValid) begin
      w_pendNext[IssueAddr] = 1'b1;
    end
    w_pendNext[0] = 1'b0;
  end

  // Population count of the next scoreboard state, registered alongside it so
  // PendCount always matches the pending bits after each edge.
  always_comb begin
    w_pendNextCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pendNextCount = w_pendNextCount + {{ADDR_W{1'b0}}, w_pendNext[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_pendCount <= '0;
    end else begin
      r_pending   <= w_pendNext;
      r_pendCount <= w_pendNextCount;
    end
  end

  assign PendCount = r_pendCount;

  // Read ports. Each port is independent combinational logic. During reset
  // the outputs are forced to zero so in-flight writes are not forwarded.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit0;
    logic              w_hit1;
    logic [DATA_W-1:0] w_data;

    assign w_addr = RdAddr[k*ADDR_W +: ADDR_W];
    assign w_hit1 = (BYPASS != 0) && w_wr1Valid && (WrAddr1 == w_addr);
    assign w_hit0 = (BYPASS != 0) && w_wr0Valid && (WrAddr0 == w_addr);

    always_comb begin
      if (!rst_n || (w_addr == '0)) begin
        w_data = '0;
      end else if (w_hit1) begin
        w_data = WrData1;
      end else if (w_hit0) begin
        w_data = WrData0;
      end else begin
        w_data = r_regs[w_addr];
      end
    end

    assign RdData[k*DATA_W +: DATA_W] = w_data;

    // A register being written this cycle is not a hazard when the write
    // data is forwarded to the reader.
    assign Busy[k] = rst_n && (w_addr != '0) && r_pending[w_addr] &&
                     !(w_hit0 || w_hit1);
  end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// ---------------------------------------------------------------------------
// tb_multi_port_reg_file
//
// Self-checking bench for multi_port_reg_file. A behavioural model (plain
// arrays for the registers and pending flags) predicts read data, hazard
// flags and the pending count every cycle. Directed scenarios are followed by
// a randomized phase.
// ---------------------------------------------------------------------------
module tb_multi_port_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 3;
  localparam int BYPASS = 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     clk;
  logic                     rst_n;
  logic                     wrEn0;
  logic [ADDR_W-1:0]        wrAddr0;
  logic [DATA_W-1:0]        wrData0;
  logic                     wrEn1;
  logic [ADDR_W-1:0]        wrAddr1;
  logic [DATA_W-1:0]        wrData1;
  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic                     issueEn;
  logic [ADDR_W-1:0]        issueAddr;
  logic [NUM_RD-1:0]        busy;
  logic [ADDR_W:0]          pendCount;

  int checkCount;
  int errorCount;

  // Reference model state.
  logic [DATA_W-1:0] modelMem  [DEPTH];
  bit                modelPend [DEPTH];

  multi_port_reg_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD),
    .BYPASS(BYPASS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WrEn0    (wrEn0),
    .WrAddr0  (wrAddr0),
    .WrData0  (wrData0),
    .WrEn1    (wrEn1),
    .WrAddr1  (wrAddr1),
    .WrData1  (wrData1),
    .RdAddr   (rdAddr),
    .RdData   (rdData),
    .IssueEn  (issueEn),
    .IssueAddr(issueAddr),
    .Busy     (busy),
    .PendCount(pendCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NUM_RD*ADDR_W-1:0] packRd(input logic [ADDR_W-1:0] a0,
                                                      input logic [ADDR_W-1:0] a1,
                                                      input logic [ADDR_W-1:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += modelPend[i] ? 1 : 0;
    return n;
  endfunction

  // Is there an enabled, forwardable write to nonzero address a this cycle?
  function automatic bit writeHits(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
    return (wrEn1 && wrAddr1 == a) || (wrEn0 && wrAddr0 == a);
  endfunction

  function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (BYPASS == 1) begin
      if (wrEn1 && wrAddr1 == a) return wrData1;
      if (wrEn0 && wrAddr0 == a) return wrData0;
    end
    return modelMem[a];
  endfunction

  function automatic bit expBusy(input logic [ADDR_W-1:0] a);
    if (!rst_n || a == 0) return 1'b0;
    if (BYPASS == 1 && writeHits(a)) return 1'b0;
    return modelPend[a];
  endfunction

  task automatic checkCycle();
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < NUM_RD; k++) begin
      a = rdAddr[k*ADDR_W +: ADDR_W];
      checkOutput($sformatf("rdData%0d@r%0d", k, a),
                  64'(rdData[k*DATA_W +: DATA_W]), 64'(expRead(a)));
      checkOutput($sformatf("busy%0d@r%0d", k, a), 64'(busy[k]), 64'(expBusy(a)));
    end
    checkOutput("pendCount", 64'(pendCount), rst_n ? 64'(modelCount()) : 64'd0);
  endtask

  // Drive one cycle of inputs at the falling edge and check the combinational
  // outputs before the next rising edge.
  task automatic applyStimulus(input logic we0, input logic [ADDR_W-1:0] wa0,
                               input logic [DATA_W-1:0] wd0,
                               input logic we1, input logic [ADDR_W-1:0] wa1,
                               input logic [DATA_W-1:0] wd1,
                               input logic ie, input logic [ADDR_W-1:0] ia,
                               input logic [NUM_RD*ADDR_W-1:0] ra);
    @(negedge clk);
    wrEn0 = we0; wrAddr0 = wa0; wrData0 = wd0;
    wrEn1 = we1; wrAddr1 = wa1; wrData1 = wd1;
    issueEn = ie; issueAddr = ia;
    rdAddr = ra;
    #2;
    checkCycle();
  endtask

  // Advance through the rising edge and apply the architectural rules.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        modelMem[i]  = '0;
        modelPend[i] = 1'b0;
      end
    end else begin
      if (wrEn0 && wrAddr0 != 0) begin
        modelMem[wrAddr0]  = wrData0;
        modelPend[wrAddr0] = 1'b0;
      end
      if (wrEn1 && wrAddr1 != 0) begin
        modelMem[wrAddr1]  = wrData1;
        modelPend[wrAddr1] = 1'b0;
      end
      if (issueEn && issueAddr != 0) modelPend[issueAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input logic [NUM_RD*ADDR_W-1:0] ra);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ra);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    wrEn0 = 0; wrAddr0 = 0; wrData0 = 0;
    wrEn1 = 0; wrAddr1 = 0; wrData1 = 0;
    issueEn = 0; issueAddr = 0; rdAddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i]  = '0;
      modelPend[i] = 1'b0;
    end

    // Reset state, with a write attempted while in reset.
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 1, 6, packRd(5, 6, 0));
    checkOutput("resetRd0", 64'(rdData[31:0]), 64'd0);
    tick();
    idle(packRd(5, 6, 1));
    tick();
    rst_n = 1'b1;

    // Write r5 then read it on two ports.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, packRd(5, 5, 0));
    tick();
    idle(packRd(5, 5, 0));
    checkOutput("r5Port0", 64'(rdData[31:0]), 64'hDEADBEEF);
    checkOutput("r5Port1", 64'(rdData[63:32]), 64'hDEADBEEF);
    tick();

    // Dual write collision on r7: port 1 wins, also through the bypass.
    applyStimulus(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, packRd(7, 7, 7));
    checkOutput("r7Bypass", 64'(rdData[31:0]), 64'h22);
    tick();
    idle(packRd(7, 0, 5));
    checkOutput("r7Stored", 64'(rdData[31:0]), 64'h22);
    tick();

    // Zero register: writes ignored, issues ignored.
    applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 0, packRd(0, 0, 0));
    checkOutput("r0Bypass", 64'(rdData[31:0]), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, packRd(0, 5, 7));
    checkOutput("r0Busy", 64'(busy[0]), 64'd0);
    checkOutput("r0Read", 64'(rdData[31:0]), 64'd0);
    tick();
    idle(packRd(0, 0, 0));
    checkOutput("r0PendCount", 64'(pendCount), 64'd0);
    tick();

    // Issue r3, r4; write r3 clears its hazard with forwarding.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, packRd(3, 4, 0));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, packRd(3, 4, 0));
    checkOutput("pend1", 64'(pendCount), 64'd1);
    checkOutput("busyR3", 64'(busy[0]), 64'd1);
    tick();
    applyStimulus(1, 3, 32'h33, 0, 0, 0, 0, 0, packRd(3, 4, 0));
    checkOutput("pend2", 64'(pendCount), 64'd2);
    checkOutput("busyR3Fwd", 64'(busy[0]), 64'd0);
    checkOutput("busyR4", 64'(busy[1]), 64'd1);
    tick();
    idle(packRd(3, 4, 0));
    checkOutput("pendAfterWb", 64'(pendCount), 64'd1);
    tick();

    // Same-cycle issue and write to r9: newer producer keeps it pending.
    applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, packRd(9, 0, 0));
    tick();
    idle(packRd(9, 4, 3));
    checkOutput("pendR9", 64'(pendCount), 64'd2);
    checkOutput("r9Data", 64'(rdData[31:0]), 64'h99);
    checkOutput("busyR9", 64'(busy[0]), 64'd1);
    tick();

    // Re-issue to a pending register does not double count.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, packRd(9, 4, 10));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, packRd(9, 4, 10));
    checkOutput("noDoubleCount", 64'(pendCount), 64'd2);
    tick();

    // Mid-cycle async reset with three registers pending and a write in flight.
    applyStimulus(1, 4, 32'hAAAA, 0, 0, 0, 1, 11, packRd(4, 9, 10));
    checkOutput("pend3", 64'(pendCount), 64'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("rstPendCount", 64'(pendCount), 64'd0);
    checkOutput("rstRdData", 64'(rdData), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkCycle();
    tick();
    idle(packRd(4, 9, 7));
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 32'h5, 0, 0, 0, 0, 0, packRd(4, 9, 10));
    tick();
    idle(packRd(1, 7, 5));
    checkOutput("postRstR1", 64'(rdData[31:0]), 64'h5);
    tick();

    // Randomized phase; addresses are biased toward a small window so that
    // collisions, forwarding and hazards occur frequently.
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] a [6];
      for (int j = 0; j < 6; j++) begin
        a[j] = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 7))
                                            : ADDR_W'($urandom);
      end
      applyStimulus(1'($urandom), a[0], $urandom,
                    1'($urandom), a[1], $urandom,
                    1'($urandom), a[2],
                    packRd(a[3], a[4], a[5]));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
